mult_shift_add_datapath: RTL and testbench
==========================================

Name: mult_shift_add_datapath

Overview:
- Datapath half of the 16x9 sequential multiplier: registers operands and runs a right-shift shift-add accumulate.
- Driven cycle-by-cycle by the six control strobes produced by the control ROM sequencer, which is the consumer side of that control word.
- Adds step counting, a product-valid pulse and a sticky overrun flag so the sequencer/datapath pairing can be checked in system.

Parameters:
WIDTH_X, 16, multiplicand width
WIDTH_Y, 9, multiplier width; also the number of shift-add steps per product

Ports:
CLK  input  1  clock, all state updates on rising edge
RST_N  input  1  asynchronous active-low reset
X_IN  input  WIDTH_X  multiplicand operand
Y_IN  input  WIDTH_Y  multiplier operand
LOAD_MX  input  1  capture X_IN into MX
LOAD_MY  input  1  capture Y_IN into MY; restart step count
SHIFT_MY  input  1  shift MY right one bit, zero fill; count one step
CLEAR_ACC  input  1  zero the accumulator
LOAD_ACC  input  1  enable conditional add of MX into accumulator high part
SHIFT_IN  input  1  shift accumulator right one bit, taking add carry in at MSB
PRODUCT  output  WIDTH_X+WIDTH_Y  accumulator contents, registered
PROD_VALID  output  1  one-cycle pulse, PRODUCT holds completed result
BUSY  output  1  high while 0 < step count < WIDTH_Y
OVERRUN  output  1  sticky: step requested after WIDTH_Y steps completed

Behaviour:
- Reset (RST_N low, asynchronous): MX, MY, ACC, step count, PROD_VALID, OVERRUN all 0. Reset mid-product discards the product; no PROD_VALID follows.
- Registers: MX[WIDTH_X], MY[WIDTH_Y], ACC[WIDTH_X+WIDTH_Y], CNT[clog2(WIDTH_Y+1)].
- HI = ACC[WIDTH_X+WIDTH_Y-1:WIDTH_Y].
- SUM = HI + ((LOAD_ACC & MY[0]) ? MX : 0), computed at WIDTH_X+1 bits.
- ACC update priority:
  - CLEAR_ACC: ACC <= 0; overrides LOAD_ACC and SHIFT_IN.
  - else SHIFT_IN: ACC <= {SUM, ACC[WIDTH_Y-1:1]}.
  - else LOAD_ACC: HI <= SUM[WIDTH_X-1:0]; carry discarded.
  - else hold.
- SUM and all step logic always use the pre-edge MY[0] and MX. Same-edge LOAD_MX or SHIFT_MY takes effect only from the next step.
- MY update: LOAD_MY has priority over SHIFT_MY. Otherwise SHIFT_MY gives MY <= {1'b0, MY[WIDTH_Y-1:1]}.
- MX update: LOAD_MX loads X_IN; otherwise hold.
- CNT update:
  - LOAD_MY: CNT <= 0, OVERRUN <= 0.
  - else SHIFT_MY with CNT < WIDTH_Y: CNT <= CNT+1.
  - else SHIFT_MY with CNT == WIDTH_Y: CNT holds, OVERRUN <= 1. The ACC/MY step still executes; the error is flagged, not blocked.
- PROD_VALID: registered. It is 1 on the cycle after the edge where CNT goes WIDTH_Y-1 -> WIDTH_Y, and 0 otherwise.
- BUSY is combinational from CNT: (CNT != 0) && (CNT != WIDTH_Y).
- Nominal control sequence:
  - Cycle 0: LOAD_MX, LOAD_MY, CLEAR_ACC.
  - WIDTH_Y step cycles: SHIFT_MY, LOAD_ACC, SHIFT_IN.
  - Then idle: all strobes 0.
  - After the last step edge, PRODUCT == MX*MY exactly; no overflow is possible at WIDTH_X+WIDTH_Y bits.
  - PRODUCT holds until the next CLEAR_ACC, SHIFT_IN or LOAD_ACC.
- The datapath acts only on the strobes present at each edge; any one-cycle lag of the registered control ROM is absorbed by the sequencer, not here.

Test Plan:
- Reset mid-run: assert RST_N=0 asynchronously after step 4 -> all outputs 0 immediately; no PROD_VALID until a new full sequence.
- Nominal: X_IN=0x1234, Y_IN=0x0AB, load cycle + 9 steps -> PRODUCT=0x00C28BC; PROD_VALID high exactly one cycle after the 9th step edge; BUSY high during steps 1-8.
- Maximum operands: X_IN=0xFFFF, Y_IN=0x1FF -> PRODUCT=0x1FEFE01, exercising the step-carry path.
- Zero and identity: Y_IN=0x000 gives PRODUCT=0; X_IN=0x0001, Y_IN=0x1FF gives PRODUCT=0x00001FF.
- Overrun: after a complete product, issue a 10th step -> OVERRUN=1 and stays 1; the next LOAD_MY clears it and CNT=0.
- Priority: CLEAR_ACC with SHIFT_IN gives ACC=0. LOAD_MY with SHIFT_MY loads Y_IN unshifted. LOAD_ACC alone with HI=0xFFFF, MX=0x0001, MY[0]=1 gives HI=0x0000 (carry dropped).

Source files
------------

// File: rtl/mult_shift_add_datapath.sv
// Datapath half of a sequential shift-add multiplier. Holds the operands, runs a
// right-shift accumulate under external control strobes, counts steps and flags
// completion (PROD_VALID) and excess steps (OVERRUN).
module mult_shift_add_datapath #(
   parameter int unsigned WIDTH_X = 16,
   parameter int unsigned WIDTH_Y = 9
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic [WIDTH_X-1:0]         X_IN,
   input  logic [WIDTH_Y-1:0]         Y_IN,
   input  logic                       LOAD_MX,
   input  logic                       LOAD_MY,
   input  logic                       SHIFT_MY,
   input  logic                       CLEAR_ACC,
   input  logic                       LOAD_ACC,
   input  logic                       SHIFT_IN,
   output logic [WIDTH_X+WIDTH_Y-1:0] PRODUCT,
   output logic                       PROD_VALID,
   output logic                       BUSY,
   output logic                       OVERRUN
);

   localparam int unsigned WidthP = WIDTH_X + WIDTH_Y;
   localparam int unsigned CntW   = $clog2(WIDTH_Y + 1);

   logic [WIDTH_X-1:0] mx_q, mx_d;
   logic [WIDTH_Y-1:0] my_q, my_d;
   logic [WidthP-1:0]  acc_q, acc_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic               prod_valid_q, prod_valid_d;
   logic               overrun_q, overrun_d;

   logic [WIDTH_X-1:0] hi;
   logic [WIDTH_X-1:0] addend;
   logic [WIDTH_X:0]   sum;

   // Conditional add of the multiplicand into the accumulator high part; uses pre-edge MX/MY.
   always_comb begin
      hi     = acc_q[WidthP-1:WIDTH_Y];
      addend = (LOAD_ACC && my_q[0]) ? mx_q : '0;
      sum    = {1'b0, hi} + {1'b0, addend};
   end

   // Next-state for operand registers and accumulator.
   always_comb begin
      mx_d  = mx_q;
      my_d  = my_q;
      acc_d = acc_q;
      if (LOAD_MX) begin
         mx_d = X_IN;
      end
      if (LOAD_MY) begin
         my_d = Y_IN;
      end else if (SHIFT_MY) begin
         my_d = {1'b0, my_q[WIDTH_Y-1:1]};
      end
      if (CLEAR_ACC) begin
         acc_d = '0;
      end else if (SHIFT_IN) begin
         // Add carry lands in the MSB as the whole word shifts right.
         acc_d = {sum, acc_q[WIDTH_Y-1:1]};
      end else if (LOAD_ACC) begin
         // Without a shift there is nowhere to keep the carry, so it is dropped.
         acc_d = {sum[WIDTH_X-1:0], acc_q[WIDTH_Y-1:0]};
      end
   end

   // Step counter, completion pulse and sticky overrun flag.
   always_comb begin
      cnt_d        = cnt_q;
      overrun_d    = overrun_q;
      prod_valid_d = 1'b0;
      if (LOAD_MY) begin
         cnt_d     = '0;
         overrun_d = 1'b0;
      end else if (SHIFT_MY) begin
         if (cnt_q < CntW'(WIDTH_Y)) begin
            cnt_d        = cnt_q + CntW'(1);
            prod_valid_d = (cnt_q == CntW'(WIDTH_Y - 1));
         end else begin
            // Step still executes on ACC/MY; only the error is recorded.
            overrun_d = 1'b1;
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         mx_q         <= '0;
         my_q         <= '0;
         acc_q        <= '0;
         cnt_q        <= '0;
         prod_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         mx_q         <= mx_d;
         my_q         <= my_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         prod_valid_q <= prod_valid_d;
         overrun_q    <= overrun_d;
      end
   end

   // Outputs: registered state, BUSY decoded from the step count.
   always_comb begin
      PRODUCT    = acc_q;
      PROD_VALID = prod_valid_q;
      OVERRUN    = overrun_q;
      BUSY       = (cnt_q != '0) && (cnt_q != CntW'(WIDTH_Y));
   end

endmodule

// File: tb/tb_mult_shift_add_datapath.sv
// Scoreboard bench for mult_shift_add_datapath: expected products are queued when a
// sequence is issued and popped by a monitor whenever PROD_VALID is seen.
module tb_mult_shift_add_datapath;

   localparam int WX = 16;
   localparam int WY = 9;

   logic             CLK = 1'b0;
   logic             RST_N;
   logic [WX-1:0]    X_IN;
   logic [WY-1:0]    Y_IN;
   logic             LOAD_MX, LOAD_MY, SHIFT_MY, CLEAR_ACC, LOAD_ACC, SHIFT_IN;
   logic [WX+WY-1:0] PRODUCT;
   logic             PROD_VALID, BUSY, OVERRUN;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];

   mult_shift_add_datapath #(.WIDTH_X(WX), .WIDTH_Y(WY)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .X_IN      (X_IN),
      .Y_IN      (Y_IN),
      .LOAD_MX   (LOAD_MX),
      .LOAD_MY   (LOAD_MY),
      .SHIFT_MY  (SHIFT_MY),
      .CLEAR_ACC (CLEAR_ACC),
      .LOAD_ACC  (LOAD_ACC),
      .SHIFT_IN  (SHIFT_IN),
      .PRODUCT   (PRODUCT),
      .PROD_VALID(PROD_VALID),
      .BUSY      (BUSY),
      .OVERRUN   (OVERRUN)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic strobes(input logic lmx, input logic lmy, input logic smy,
                          input logic clr, input logic lacc, input logic sin);
      LOAD_MX   = lmx;
      LOAD_MY   = lmy;
      SHIFT_MY  = smy;
      CLEAR_ACC = clr;
      LOAD_ACC  = lacc;
      SHIFT_IN  = sin;
   endtask

   // Inputs are changed at negedge; one tick crosses one rising edge.
   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   // Nominal sequence: load cycle, WY step cycles, one idle cycle.
   task automatic run_product(input logic [WX-1:0] x, input logic [WY-1:0] y,
                              input logic shift_on_load);
      logic [31:0] expv;
      expv = 32'(x) * 32'(y);
      X_IN = x;
      Y_IN = y;
      exp_q.push_back(expv);
      strobes(1'b1, 1'b1, shift_on_load, 1'b1, 1'b0, 1'b0);
      tick();
      check("busy_after_load", 32'(BUSY), 32'd0);
      check("acc_cleared", 32'(PRODUCT), 32'd0);
      // Operand inputs are don't-care once captured.
      X_IN = 16'($urandom);
      Y_IN = 9'($urandom);
      for (int k = 1; k <= WY; k++) begin
         strobes(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
         tick();
         check("busy_step", 32'(BUSY), (k < WY) ? 32'd1 : 32'd0);
         check("valid_step", 32'(PROD_VALID), (k == WY) ? 32'd1 : 32'd0);
      end
      strobes(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      check("valid_one_cycle", 32'(PROD_VALID), 32'd0);
      check("product_hold", 32'(PRODUCT), expv);
   endtask

   // Monitor: compare every presented product against the scoreboard head.
   initial begin
      forever begin
         @(negedge CLK);
         if (RST_N === 1'b1 && PROD_VALID === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_valid: got PRODUCT=0x%0h expected no valid", PRODUCT);
            end else begin
               check("product", 32'(PRODUCT), exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [WX-1:0] hi_model;
      RST_N = 1'b0;
      X_IN  = '0;
      Y_IN  = '0;
      strobes(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      check("reset_product", 32'(PRODUCT), 32'd0);
      check("reset_valid", 32'(PROD_VALID), 32'd0);
      check("reset_busy", 32'(BUSY), 32'd0);
      check("reset_overrun", 32'(OVERRUN), 32'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      tick();

      run_product(16'h1234, 9'h0AB, 1'b0);
      check("nominal_value", 32'(PRODUCT), 32'h00C28BC);
      check("no_overrun", 32'(OVERRUN), 32'd0);
      run_product(16'hFFFF, 9'h1FF, 1'b0);
      check("max_value", 32'(PRODUCT), 32'h1FEFE01);
      run_product(16'hBEEF, 9'h000, 1'b0);
      run_product(16'h0001, 9'h1FF, 1'b0);

      // Extra step after completion.
      strobes(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      check("overrun_set", 32'(OVERRUN), 32'd1);
      check("overrun_no_valid", 32'(PROD_VALID), 32'd0);
      check("overrun_busy", 32'(BUSY), 32'd0);
      strobes(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      check("overrun_sticky", 32'(OVERRUN), 32'd1);
      Y_IN = 9'h003;
      strobes(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      check("overrun_cleared", 32'(OVERRUN), 32'd0);
      check("cnt_zero_busy", 32'(BUSY), 32'd0);
      strobes(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check("cnt_one_busy", 32'(BUSY), 32'd1);
      strobes(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();

      // CLEAR_ACC wins over SHIFT_IN and LOAD_ACC.
      run_product(16'h1234, 9'h0AB, 1'b0);
      strobes(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      tick();
      check("clear_priority", 32'(PRODUCT), 32'd0);

      // LOAD_MY wins over SHIFT_MY: full unshifted product expected.
      run_product(16'h0F0F, 9'h155, 1'b1);

      // LOAD_ACC alone: HI += MX modulo 2^WX, low part untouched.
      X_IN = 16'hFFFF;
      Y_IN = 9'h1FF;
      strobes(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      hi_model = 16'h0000 + 16'hFFFF;
      strobes(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      check("load_acc_hi", 32'(PRODUCT), 32'(hi_model) << WY);
      X_IN = 16'h0001;
      strobes(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      check("load_mx_hold_acc", 32'(PRODUCT), 32'(hi_model) << WY);
      hi_model = hi_model + 16'h0001;
      strobes(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      check("load_acc_carry_drop", 32'(PRODUCT), 32'(hi_model) << WY);

      // Reset after four steps: product discarded, no valid afterwards.
      X_IN = 16'hFFFF;
      Y_IN = 9'h1FF;
      strobes(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      for (int k = 0; k < 4; k++) begin
         strobes(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
         tick();
      end
      #2;
      RST_N = 1'b0;
      #1;
      check("midrun_reset_product", 32'(PRODUCT), 32'd0);
      check("midrun_reset_valid", 32'(PROD_VALID), 32'd0);
      check("midrun_reset_busy", 32'(BUSY), 32'd0);
      check("midrun_reset_overrun", 32'(OVERRUN), 32'd0);
      strobes(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge CLK);
      RST_N = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
      end

      // Random operands with random idle gaps.
      for (int n = 0; n < 20; n++) begin
         int gap;
         run_product(16'($urandom), 9'($urandom), 1'b0);
         gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) begin
            tick();
         end
      end

      tick();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
